display_refresh_scheduler: RTL and testbench

//  Sits between the frequency measurement core and data_streamer. It decides when the OLED is redrawn.
//  - Latches each new BCD result.
//  - Applies leading-zero blanking.
//  - Rate-limits redraws to one per MIN_INTERVAL cycles.
//  - Issues the refresh strobe only when the streamer reports idle.
//  - Results that arrive while a redraw is pending are coalesced: the newest result wins and an overrun counter is bumped.

---
 rtl/display_refresh_scheduler.sv | 158 +++++++++++++++
 tb/tb_display_refresh_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_refresh_scheduler.sv
// display_refresh_scheduler
// Decides when the OLED gets redrawn. Each new BCD result from the frequency
// core is latched and leading-zero blanked. A refresh strobe goes to the data
// streamer only when the streamer is idle, and redraws are rate-limited by a
// holdoff period. A result that arrives while an older one is still waiting
// replaces it, and the overrun counter records the replacement.
module display_refresh_scheduler #(
    parameter int         DIGITS_NUM    = 6,
    parameter int         MIN_INTERVAL  = 1200000,
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [3:0] BLANK_CODE    = 4'hF,
    parameter int         OVR_W         = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [4*DIGITS_NUM-1:0] value_in,
    input  logic                    value_valid_in,
    output logic [4*DIGITS_NUM-1:0] digits_out,
    output logic                    refresh_stb_out,
    input  logic                    streamer_ready_in,
    output logic                    pending_out,
    output logic                    busy_out,
    output logic [OVR_W-1:0]        overrun_cnt_out
);

    // The holdoff counter only ever holds values up to MIN_INTERVAL-1.
    localparam int HOLD_W = (MIN_INTERVAL > 1) ? $clog2(MIN_INTERVAL) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (MIN_INTERVAL > 0) ? HOLD_W'(MIN_INTERVAL - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLDOFF
    } state_t;

    state_t                  state_reg;
    logic [4*DIGITS_NUM-1:0] digits_reg;
    logic                    refresh_stb_reg;
    logic                    pending_reg;
    logic [4*DIGITS_NUM-1:0] pending_value_reg;
    logic [OVR_W-1:0]        overrun_reg;
    logic [HOLD_W-1:0]       hold_cnt_reg;
    logic [1:0]              ready_run_reg;

    logic                    issue_now;
    logic [4*DIGITS_NUM-1:0] blanked_value;

    // A pending result is handed to the streamer this cycle.
    assign issue_now = (state_reg == S_IDLE) && pending_reg && streamer_ready_in;

    // Leading-zero blanking of the pending value. zero_above[k] is set when
    // digits k..DIGITS_NUM-1 are all zero. Digit 0 always passes through, so
    // an all-zero value still shows a single '0'. Nibbles above 9 count as
    // nonzero, so they stop the blanking and are shown unchanged.
    if (BLANK_LEADING) begin : g_blank
        logic [DIGITS_NUM:1] zero_above;

        assign zero_above[DIGITS_NUM] = 1'b1;
        assign blanked_value[3:0]     = pending_value_reg[3:0];

        for (genvar gi = 1; gi < DIGITS_NUM; gi++) begin : g_digit
            assign zero_above[gi] = zero_above[gi+1] &
                                    (pending_value_reg[4*gi +: 4] == 4'd0);
            assign blanked_value[4*gi +: 4] =
                zero_above[gi] ? BLANK_CODE : pending_value_reg[4*gi +: 4];
        end
    end else begin : g_no_blank
        assign blanked_value = pending_value_reg;
    end

    // Capture logic, overrun accounting and the refresh FSM. All outputs are
    // registered.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg         <= S_IDLE;
            digits_reg        <= '0;
            refresh_stb_reg   <= 1'b0;
            pending_reg       <= 1'b0;
            pending_value_reg <= '0;
            overrun_reg       <= '0;
            hold_cnt_reg      <= '0;
            ready_run_reg     <= '0;
        end else begin
            refresh_stb_reg <= 1'b0;

            // A new result always overwrites the pending slot. It counts as an
            // overrun only when an older result is lost without being issued.
            if (value_valid_in) begin
                pending_value_reg <= value_in;
                pending_reg       <= 1'b1;
                if (pending_reg && !issue_now && (overrun_reg != {OVR_W{1'b1}})) begin
                    overrun_reg <= overrun_reg + 1'b1;
                end
            end else if (issue_now) begin
                pending_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (issue_now) begin
                        digits_reg      <= blanked_value;
                        refresh_stb_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    ready_run_reg <= '0;
                    state_reg     <= S_WAIT_BUSY;
                end

                // If the streamer never drops ready, the strobe was probably
                // missed, so send it again with the same digits.
                S_WAIT_BUSY: begin
                    if (!streamer_ready_in) begin
                        state_reg <= S_WAIT_DONE;
                    end else if (ready_run_reg == 2'd3) begin
                        refresh_stb_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end else begin
                        ready_run_reg <= ready_run_reg + 1'b1;
                    end
                end

                S_WAIT_DONE: begin
                    if (streamer_ready_in) begin
                        if (MIN_INTERVAL == 0) begin
                            state_reg <= S_IDLE;
                        end else begin
                            hold_cnt_reg <= HOLD_LOAD;
                            state_reg    <= S_HOLDOFF;
                        end
                    end
                end

                S_HOLDOFF: begin
                    if (hold_cnt_reg == '0) begin
                        state_reg <= S_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 1'b1;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign digits_out      = digits_reg;
    assign refresh_stb_out = refresh_stb_reg;
    assign pending_out     = pending_reg;
    assign busy_out        = (state_reg != S_IDLE);
    assign overrun_cnt_out = overrun_reg;

endmodule

// File: tb/tb_display_refresh_scheduler.sv
// tb_display_refresh_scheduler
// Directed stimulus. The expected digits for each refresh strobe are queued
// when the stimulus is issued, and a forked monitor pops and compares them
// whenever the DUT strobes. A second instance runs without blanking on the
// same inputs.
module tb_display_refresh_scheduler;

    typedef struct packed {
        logic [23:0] blk;
        logic [23:0] raw;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [23:0] value;
    logic        valid;
    logic        ready;

    logic [23:0] digits;
    logic        stb;
    logic        pending;
    logic        busy;
    logic [7:0]  ovr;

    logic [23:0] digits_nb;
    logic        stb_nb;
    logic        pending_nb;
    logic        busy_nb;
    logic [7:0]  ovr_nb;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    display_refresh_scheduler #(
        .DIGITS_NUM(6), .MIN_INTERVAL(10), .BLANK_LEADING(1'b1),
        .BLANK_CODE(4'hF), .OVR_W(8)
    ) dut (
        .clk_in(clk), .reset_in(rst), .value_in(value), .value_valid_in(valid),
        .digits_out(digits), .refresh_stb_out(stb), .streamer_ready_in(ready),
        .pending_out(pending), .busy_out(busy), .overrun_cnt_out(ovr)
    );

    display_refresh_scheduler #(
        .DIGITS_NUM(6), .MIN_INTERVAL(10), .BLANK_LEADING(1'b0),
        .BLANK_CODE(4'hF), .OVR_W(8)
    ) dut_nb (
        .clk_in(clk), .reset_in(rst), .value_in(value), .value_valid_in(valid),
        .digits_out(digits_nb), .refresh_stb_out(stb_nb), .streamer_ready_in(ready),
        .pending_out(pending_nb), .busy_out(busy_nb), .overrun_cnt_out(ovr_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, got, exp);
        end
    endtask

    // Drive inputs 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each strobe must match the oldest queued expectation.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (stb) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stb actual=strobe digits %h required=no strobe", digits);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_digits", 32'(digits), 32'(e.blk));
                    check("sb_digits_noblank", 32'(digits_nb), 32'(e.raw));
                    check("sb_stb_noblank", 32'(stb_nb), 32'd1);
                    $display("strobe digits=%h noblank=%h expected=%h/%h", digits, digits_nb, e.blk, e.raw);
                end
            end
        end
    endtask

    // Waits a bounded number of cycles for a strobe; ends on its negedge.
    task automatic wait_stb(input string name, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (stb) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_digits"},  32'(digits),  32'd0);
        check({tag, "_stb"},     32'(stb),     32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_ovr"},     32'(ovr),     32'd0);
        check({tag, "_nb_pend"}, 32'(pending_nb), 32'd0);
        check({tag, "_nb_busy"}, 32'(busy_nb),    32'd0);
    endtask

    initial begin
        int busy_cycles;
        fork
            monitor_loop();
        join_none

        rst   = 1'b1;
        value = '0;
        valid = 1'b0;
        ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Test 1: strobe two cycles after the valid pulse, leading zeros blanked.
        step();
        value = 24'h001234;
        valid = 1'b1;
        exp_q.push_back('{blk: 24'hFF1234, raw: 24'h001234});
        step();
        valid = 1'b0;
        @(negedge clk);
        check("c1_stb", 32'(stb), 32'd0);
        check("c1_pending", 32'(pending), 32'd1);
        step();
        @(negedge clk);
        check("c2_stb", 32'(stb), 32'd1);
        check("c2_busy", 32'(busy), 32'd1);
        check("c2_pending", 32'(pending), 32'd0);

        // Test 2: streamer drops ready for 50 cycles, then raises it.
        step();
        ready = 1'b0;
        @(negedge clk);
        check("c3_stb", 32'(stb), 32'd0);
        repeat (50) @(posedge clk);
        #1;
        ready = 1'b1;

        // Test 3: three results arrive during holdoff. Only the newest one is
        // shown. busy_out covers the single WAIT_DONE cycle that registers the
        // rising ready, plus MIN_INTERVAL holdoff cycles.
        exp_q.push_back('{blk: 24'hFFFFF3, raw: 24'h000003});
        exp_q.push_back('{blk: 24'hFFFFF3, raw: 24'h000003});
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            step();
            valid = (i < 3);
            value = 24'(i + 1);
        end
        valid = 1'b0;
        check("holdoff_len", 32'(busy_cycles), 32'd11);
        check("holdoff_ovr", 32'(ovr), 32'd2);
        check("holdoff_pending", 32'(pending), 32'd1);
        step();
        @(negedge clk);
        check("post_holdoff_stb", 32'(stb), 32'd1);

        // Test 5: ready stays high, so the same digits are strobed again.
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check($sformatf("restrobe_stb_%0d", k), 32'(stb), (k == 4) ? 32'd1 : 32'd0);
        end

        // Reset while in WAIT_DONE with a result pending.
        step();
        ready = 1'b0;
        valid = 1'b1;
        value = 24'h000777;
        step();
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("pre_reset_pending", 32'(pending), 32'd1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");

        // Test 4: valid on the IDLE->ISSUE edge. The old value is issued and the
        // new value stays pending with no overrun. The non-BCD nibble passes
        // through and the inner zeros stay visible.
        step();
        value = 24'h0A0300;
        valid = 1'b1;
        exp_q.push_back('{blk: 24'hFA0300, raw: 24'h0A0300});
        exp_q.push_back('{blk: 24'hFFFF42, raw: 24'h000042});
        step();
        value = 24'h000042;
        valid = 1'b1;
        ready = 1'b1;
        step();
        valid = 1'b0;
        @(negedge clk);
        check("same_edge_stb", 32'(stb), 32'd1);
        check("same_edge_pending", 32'(pending), 32'd1);
        check("same_edge_ovr", 32'(ovr), 32'd0);
        step();
        ready = 1'b0;
        step();
        step();
        ready = 1'b1;
        wait_stb("second_value_stb", 40);
        step();
        ready = 1'b0;
        @(negedge clk);
        check("after_second_pending", 32'(pending), 32'd0);
        check("after_second_ovr", 32'(ovr), 32'd0);

        // Test 6: 300 results with ready low. The overrun counter saturates,
        // and the final all-zero value is shown as a single '0'.
        for (int i = 0; i < 300; i++) begin
            step();
            valid = 1'b1;
            value = (i == 299) ? 24'h000000 : 24'(i + 1);
            if (i == 255 || i == 256) begin
                @(negedge clk);
                check($sformatf("ovr_at_%0d", i), 32'(ovr), (i == 255) ? 32'd254 : 32'd255);
            end
        end
        step();
        valid = 1'b0;
        @(negedge clk);
        check("ovr_saturated", 32'(ovr), 32'd255);
        check("ovr_saturated_nb", 32'(ovr_nb), 32'd255);
        exp_q.push_back('{blk: 24'hFFFFF0, raw: 24'h000000});
        step();
        ready = 1'b1;
        wait_stb("zero_value_stb", 40);
        step();
        ready = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
